// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory responder:
// access-size encodings, FSM state encoding and legal wait-state range.
package dmem_pkg;

  // Access size encodings; 2'b11 is reserved and behaves as a word access.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Legal range for the number of stall cycles per accepted access.
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Little-endian byte-lane steering: store merge / byte mask and load extract + extend.
// Latency: purely combinational.
// Backpressure: none; it only reshapes data for the responder.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] rd_word_i,
  output logic [31:0] merged_o,
  output logic [3:0]  be_o,
  output logic [31:0] load_o
);

  logic [31:0] wlane;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Replicate right-aligned store data into every lane it may target and pick the lanes.
  always_comb begin
    be_o  = 4'b1111;
    wlane = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o  = 4'b0001 << addr_lo_i;
        wlane = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Unselected lanes keep the old word contents.
  always_comb begin
    merged_o = old_word_i;
    for (int i = 0; i < 4; i++) begin
      if (be_o[i]) merged_o[8*i +: 8] = wlane[8*i +: 8];
    end
  end

  // Pull the addressed lanes down to bit 0 and extend; word loads ignore sign.
  always_comb begin
    rd_byte = rd_word_i[{addr_lo_i, 3'b000} +: 8];
    rd_half = addr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
    case (size_i)
      SZ_BYTE: load_o = {{24{sign_i & rd_byte[7]}}, rd_byte};
      SZ_HALF: load_o = {{16{sign_i & rd_half[15]}}, rd_half};
      default: load_o = rd_word_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory: word storage with fixed wait states, stall to pipeline, formatted loads.
// Latency: stall for LATENCY cycles from the request cycle, done pulse in cycle LATENCY.
// Backpressure: stall_mem holds the pipeline; dropping req while BUSY aborts the access.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic        stall_mem,
  output logic [31:0] rdata,
  output logic        done,
  output logic        addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("dmem_responder: LATENCY out of range 1..15");
  end

  logic [31:0]      mem_q [DEPTH];
  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [31:0]      rdata_q;

  logic             misaligned;
  logic             out_of_range;
  logic             accept;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word;
  logic [31:0]      merged;
  logic [3:0]       be;
  logic [31:0]      load_fmt;

  assign idx     = addr[IDX_W+1:2];
  assign rd_word = mem_q[idx];

  // Alignment rule per access size; reserved size is checked like a word.
  always_comb begin
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr[0];
      default: misaligned = (addr[1:0] != 2'b00);
    endcase
  end

  assign out_of_range = {2'b00, addr[31:2]} >= 32'(DEPTH);
  assign addr_err     = req & (misaligned | out_of_range);
  assign accept       = (state_q == IDLE) & req & ~addr_err;

  // Request cycle stalls combinationally so the pipeline never advances past an accepted access.
  assign stall_mem = accept | (state_q == BUSY);
  assign done      = (state_q == DONE);
  assign rdata     = rdata_q;

  dmem_lane_fmt u_lane_fmt (
    .addr_lo_i  (addr[1:0]),
    .size_i     (size),
    .sign_i     (sign),
    .wdata_i    (wdata),
    .old_word_i (rd_word),
    .rd_word_i  (rd_word),
    .merged_o   (merged),
    .be_o       (be),
    .load_o     (load_fmt)
  );

  // Access sequencing: count wait states, capture load data on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state_q <= DONE;
              if (!we) rdata_q <= load_fmt;
            end else begin
              state_q <= BUSY;
              cnt_q   <= 4'(LATENCY - 2);
            end
          end
        end
        BUSY: begin
          if (!req) begin
            state_q <= IDLE;
          end else if (cnt_q == 4'd0) begin
            state_q <= DONE;
            if (!we) rdata_q <= load_fmt;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Store commits in the DONE cycle; a reset in that cycle cancels it.
  always_ff @(posedge clk) begin
    if (!rst && state_q == DONE && we && be != 4'b0000) begin
      mem_q[idx] <= merged;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 instance for most scenarios, LATENCY=1 instance for back-to-back.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic        we;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        sign;
  logic        stall0, done0, err0, stall1, done1, err1;
  logic [31:0] rdata0, rdata1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] sb_q[$];

  dmem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata),
    .size(size), .sign(sign), .stall_mem(stall0), .rdata(rdata0), .done(done0),
    .addr_err(err0)
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .we(we), .addr(addr), .wdata(wdata),
    .size(size), .sign(sign), .stall_mem(stall1), .rdata(rdata1), .done(done1),
    .addr_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Drives one access on the selected instance and reports what came back.
  // Starts and ends just after a rising edge; req is dropped when the done cycle ends.
  task automatic access(input bit sel, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz, input logic sg,
                        output bit got, output int stalls, output int lat,
                        output int dcyc, output logic [31:0] rd);
    we = w; addr = a; wdata = d; size = sz; sign = sg;
    if (sel) req1 = 1'b1; else req0 = 1'b1;
    got = 1'b0; stalls = 0; lat = -1; dcyc = -1; rd = 32'h0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (sel ? stall1 : stall0) stalls++;
      if (sel ? done1 : done0) begin
        got = 1'b1; lat = c; dcyc = cyc; rd = sel ? rdata1 : rdata0;
      end
      @(posedge clk); #1;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    we = 1'b0; addr = 32'h0; wdata = 32'h0; size = SZ_WORD; sign = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({stall0, done0, rdata0, stall1, done1, rdata1} !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
        bad++;
        $display("FAIL reset_idle[%0d]: got stall=%b done=%b rdata=%h / stall1=%b done1=%b rdata1=%h, want 0 0 00000000",
                 i, stall0, done0, rdata0, stall1, done1, rdata1);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    bit got; int st, lat, dc; logic [31:0] rd, exp;
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, SZ_WORD, 1'b0, got, st, lat, dc, rd);
    total++;
    if (!got || st != 2 || lat != 2) begin
      bad++;
      $display("FAIL sw_word: got done=%b stalls=%0d done_at=%0d, want 1 2 2", got, st, lat);
    end
    sb_q.push_back(32'hDEADBEEF);
    access(0, 1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, got, st, lat, dc, rd);
    exp = sb_q.pop_front();
    total++;
    if (!got || st != 2 || lat != 2 || rd !== exp) begin
      bad++;
      $display("FAIL lw_word: got done=%b stalls=%0d done_at=%0d rdata=%h, want 1 2 2 %h", got, st, lat, rd, exp);
    end
  endtask

  task automatic test_format();
    logic [31:0] ta [5] = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h12};
    logic [1:0]  ts [5] = '{SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF, SZ_HALF};
    logic        tg [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] te [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD, 32'hFFFFDEAD};
    bit got; int st, lat, dc; logic [31:0] rd, exp;
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back(te[i]);
      access(0, 1'b0, ta[i], 32'h0, ts[i], tg[i], got, st, lat, dc, rd);
      exp = sb_q.pop_front();
      total++;
      if (!got || rd !== exp) begin
        bad++;
        $display("FAIL fmt_load[%0d] addr=%h: got done=%b rdata=%h, want %h", i, ta[i], got, rd, exp);
      end
    end
    access(0, 1'b1, 32'h11, 32'h00000012, SZ_BYTE, 1'b0, got, st, lat, dc, rd);
    sb_q.push_back(32'hDEAD12EF);
    access(0, 1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, got, st, lat, dc, rd);
    exp = sb_q.pop_front();
    total++;
    if (!got || rd !== exp) begin
      bad++;
      $display("FAIL sb_merge: got done=%b rdata=%h, want %h", got, rd, exp);
    end
  endtask

  task automatic test_errors();
    logic [31:0] ea [3] = '{32'h12, 32'h11, 32'h1000};
    logic [1:0]  es [3] = '{SZ_WORD, SZ_HALF, SZ_WORD};
    logic        ew [3] = '{1'b1, 1'b0, 1'b1};
    bit got; int st, lat, dc; logic [31:0] rd, exp;
    for (int i = 0; i < 3; i++) begin
      bit ok_err = 1'b1;
      bit ok_quiet = 1'b1;
      we = ew[i]; addr = ea[i]; wdata = 32'h0; size = es[i]; sign = 1'b0; req0 = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (err0 !== 1'b1) ok_err = 1'b0;
        if (stall0 !== 1'b0 || done0 !== 1'b0) ok_quiet = 1'b0;
        @(posedge clk); #1;
      end
      req0 = 1'b0;
      total++;
      if (!ok_err) begin
        bad++;
        $display("FAIL addr_err[%0d] addr=%h: got addr_err=%b, want 1", i, ea[i], err0);
      end
      total++;
      if (!ok_quiet) begin
        bad++;
        $display("FAIL err_quiet[%0d] addr=%h: got stall/done activity, want stall=0 done=0", i, ea[i]);
      end
    end
    sb_q.push_back(32'hDEAD12EF);
    access(0, 1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, got, st, lat, dc, rd);
    exp = sb_q.pop_front();
    total++;
    if (!got || st != 2 || rd !== exp) begin
      bad++;
      $display("FAIL err_nowrite: got done=%b stalls=%0d rdata=%h, want 1 2 %h", got, st, rd, exp);
    end
  endtask

  task automatic test_abort();
    bit got; int st, lat, dc; logic [31:0] rd, exp;
    bit saw_done = 1'b0;
    bit late_stall = 1'b0;
    access(0, 1'b1, 32'h20, 32'hA5A5A5A5, SZ_WORD, 1'b0, got, st, lat, dc, rd);
    we = 1'b1; addr = 32'h20; wdata = 32'h00000055; size = SZ_WORD; req0 = 1'b1;
    @(negedge clk);
    total++;
    if (stall0 !== 1'b1) begin
      bad++;
      $display("FAIL abort_accept: got stall=%b, want 1", stall0);
    end
    @(posedge clk); #1;
    req0 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done0 === 1'b1) saw_done = 1'b1;
      if (c > 0 && stall0 !== 1'b0) late_stall = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (saw_done || late_stall) begin
      bad++;
      $display("FAIL abort_quiet: got done_seen=%b stall_after=%b, want 0 0", saw_done, late_stall);
    end
    sb_q.push_back(32'hA5A5A5A5);
    access(0, 1'b0, 32'h20, 32'h0, SZ_WORD, 1'b0, got, st, lat, dc, rd);
    exp = sb_q.pop_front();
    total++;
    if (!got || rd !== exp) begin
      bad++;
      $display("FAIL abort_nowrite: got done=%b rdata=%h, want %h", got, rd, exp);
    end
  endtask

  task automatic test_reset_busy();
    bit got; int st, lat, dc; logic [31:0] rd, exp;
    bit saw_done = 1'b0;
    we = 1'b1; addr = 32'h20; wdata = 32'h00000099; size = SZ_WORD; req0 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; req0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({stall0, done0, rdata0} !== {1'b0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL rst_busy: got stall=%b done=%b rdata=%h, want 0 0 00000000", stall0, done0, rdata0);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done0 === 1'b1) saw_done = 1'b1;
    end
    @(posedge clk); #1;
    sb_q.push_back(32'hA5A5A5A5);
    access(0, 1'b0, 32'h20, 32'h0, SZ_WORD, 1'b0, got, st, lat, dc, rd);
    exp = sb_q.pop_front();
    total++;
    if (saw_done || !got || rd !== exp) begin
      bad++;
      $display("FAIL rst_nocommit: got stray_done=%b done=%b rdata=%h, want 0 1 %h", saw_done, got, rd, exp);
    end
  endtask

  task automatic test_back_to_back();
    bit got_a, got_b; int st_a, st_b, lat, dc_a, dc_b, t0; logic [31:0] rd_a, rd_b, exp;
    access(1, 1'b1, 32'h0, 32'h11111111, SZ_WORD, 1'b0, got_a, st_a, lat, dc_a, rd_a);
    access(1, 1'b1, 32'h4, 32'h22222222, SZ_WORD, 1'b0, got_a, st_a, lat, dc_a, rd_a);
    t0 = cyc;
    sb_q.push_back(32'h11111111);
    access(1, 1'b0, 32'h0, 32'h0, SZ_WORD, 1'b0, got_a, st_a, lat, dc_a, rd_a);
    sb_q.push_back(32'h22222222);
    access(1, 1'b0, 32'h4, 32'h0, SZ_WORD, 1'b0, got_b, st_b, lat, dc_b, rd_b);
    exp = sb_q.pop_front();
    total++;
    if (!got_a || st_a != 1 || dc_a - t0 != 1 || rd_a !== exp) begin
      bad++;
      $display("FAIL lat1_first: got done=%b stalls=%0d done_cycle=%0d rdata=%h, want 1 1 1 %h",
               got_a, st_a, dc_a - t0, rd_a, exp);
    end
    exp = sb_q.pop_front();
    total++;
    if (!got_b || st_b != 1 || dc_b - t0 != 3 || rd_b !== exp) begin
      bad++;
      $display("FAIL lat1_second: got done=%b stalls=%0d done_cycle=%0d rdata=%h, want 1 1 3 %h",
               got_b, st_b, dc_b - t0, rd_b, exp);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_format();
    test_errors();
    test_abort();
    test_reset_busy();
    test_back_to_back();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
